// File: rtl/max_bus_master.sv
// max_bus_master: PHI2-aligned 6510-style bus cycle initiator with stolen-cycle retry.
// Define MAX_BUS_TIMEOUT_EN to abandon a request after 255 consecutive stolen cycles.
module max_bus_master #(
    parameter int PHASE_DIV = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [15:0] REQ_ADDR,
    input  logic [7:0]  REQ_WDATA,
    output logic        RSP_VALID,
    output logic [7:0]  RSP_RDATA,
    output logic        RSP_ERR,
    output logic        PHI2,
    output logic [15:0] A,
    output logic        RW,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic [7:0]  D_IN,
    input  logic        BA
);
    localparam int CW = $clog2(PHASE_DIV);
    typedef enum logic [1:0] {IDLE, WAIT, ADDR, DATA} state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic we, wrap, p1s, rise, accept, done, abort;
    assign wrap = cnt == CW'(PHASE_DIV - 1);
    // the sample point and phase-1 start share one edge: PHI2 falls as BA/D_IN are taken
    assign p1s = wrap & PHI2;
    assign rise = wrap & ~PHI2;
    assign REQ_READY = state == IDLE;
    assign accept = REQ_VALID & REQ_READY;
    assign done = (state == DATA) & p1s & BA;
`ifdef MAX_BUS_TIMEOUT_EN
    logic [7:0] retries;
    assign abort = (state == DATA) & p1s & ~BA & (retries == 8'd254);
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            retries <= '0;
            RSP_ERR <= 1'b0;
        end else begin
            RSP_ERR <= abort;
            if (accept) retries <= '0;
            else if ((state == DATA) & p1s & ~BA) retries <= retries + 8'd1;
        end
    end
`else
    assign abort = 1'b0;
    assign RSP_ERR = 1'b0;
`endif
    always_comb begin
        nxt = state == IDLE ? (accept ? WAIT : IDLE)
            : state == WAIT ? (p1s ? ADDR : WAIT)
            : state == ADDR ? (rise ? DATA : ADDR)
            : (p1s ? ((BA | abort) ? IDLE : ADDR) : DATA);
    end
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt <= '0;
            PHI2 <= 1'b0;
            we <= 1'b0;
            A <= '0;
            RW <= 1'b1;
            D_OUT <= '0;
            D_OE <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
        end else begin
            state <= nxt;
            cnt <= wrap ? '0 : cnt + 1'b1;
            PHI2 <= PHI2 ^ wrap;
            RW <= (nxt == IDLE) | ~(accept ? REQ_WE : we);
            D_OE <= (nxt == DATA) & we;
            RSP_VALID <= done | abort;
            if (accept) begin
                we <= REQ_WE;
                A <= REQ_ADDR;
                D_OUT <= REQ_WDATA;
            end
            if (done & ~we) RSP_RDATA <= D_IN;
            if (abort) RSP_RDATA <= 8'hFF;
        end
    end
endmodule
